led_scan_ctrl: RTL and testbench
================================

LED_SCAN_CTRL -- requirements
Module: led_scan_ctrl

Interface
REQ-001 Parameter T_SLOT, default 25'd20_000_000: slot length in CLK cycles, 100 ms at 200 MHz; legal range 2..2^25-1.
REQ-002 Parameter ON_START, default 25'd15_000_000: first slot count at which the active LED window opens.
REQ-003 Parameter ON_END, default 25'd20_000_000: slot count at which the active LED window closes (exclusive); legal values satisfy 0 <= ON_START < ON_END <= T_SLOT.
REQ-004 CLK  input  1  sole clock; all state updates on its rising edge.
REQ-005 RST  input  1  reset, asynchronous, active-high.
REQ-006 Start_Sig  input  1  level sampled each cycle; starts a scan when IDLE.
REQ-007 Stop_Sig  input  1  level sampled each cycle; requests an orderly stop.
REQ-008 Mode  input  2  scan pattern: 00 forward, 01 reverse, 10 ping-pong, 11 all-blink.
REQ-009 LED_Out  output  4  registered LED drive, one bit per channel.
REQ-010 Busy  output  1  registered; high when state is not IDLE.
REQ-011 Slot_Done  output  1  registered one-cycle pulse at each slot end.

Function
REQ-012 FSM states: IDLE, RUN, DRAIN.
REQ-013 IDLE -> RUN on Start_Sig=1 with Stop_Sig=0; Start_Sig=1 with Stop_Sig=1 in IDLE keeps IDLE (stop wins).
REQ-014 RUN -> DRAIN on Stop_Sig=1; Start_Sig is ignored in RUN and DRAIN; Stop_Sig is ignored in IDLE and DRAIN.
REQ-015 DRAIN -> IDLE when slot counter equals T_SLOT-1.
REQ-016 On the IDLE->RUN edge, Count <= 0 and the pattern register Mode_r <= Mode; the direction bit is set to up; Ch <= 3 if Mode=01, otherwise Ch <= 0.
REQ-017 Mode is sampled only at start; Mode changes while Busy=1 have no effect.
REQ-018 Count (25 bits) increments every cycle in RUN and DRAIN, wraps from T_SLOT-1 to 0, and is held at 0 in IDLE.
REQ-019 At a wrap in RUN, Ch advances: forward +1 with 3->0 wrap; reverse -1 with 0->3 wrap; ping-pong sequence 0,1,2,3,2,1,0,1,..., reversing the direction bit at 3 and at 0; all-blink leaves Ch unchanged.
REQ-020 At the DRAIN->IDLE transition, Ch does not advance.
REQ-021 LED_Out is registered, with 1-cycle latency from Count: in RUN or DRAIN, if ON_START <= Count < ON_END, the next LED_Out is one-hot on Ch (all-blink: 4'b1111); otherwise the next LED_Out is 4'b0000.
REQ-022 In IDLE, LED_Out is 4'b0000 from the cycle after entering IDLE.
REQ-023 Slot_Done is registered 1 on the cycle after Count = T_SLOT-1 in RUN or DRAIN, and 0 otherwise; it pulses on the final drained slot too.
REQ-024 Busy is registered and equals (next state != IDLE); it is 1 starting the cycle after the Start edge and 0 starting the cycle after DRAIN ends.
REQ-025 The compare for ON_END = T_SLOT means the window closes at the wrap; no count beyond T_SLOT-1 ever occurs.

Reset
REQ-026 RST=1 forces, asynchronously: state=IDLE, Count=0, Ch=0, direction=up, Mode_r=00, LED_Out=4'b0000, Busy=0, Slot_Done=0.
REQ-027 RST asserted mid-RUN or mid-DRAIN aborts the scan immediately with no drain; after release, the block is IDLE until a new Start_Sig.

Verification (bench parameters T_SLOT=10, ON_START=6, ON_END=9)
REQ-028 Forward: Mode=00, 1-cycle Start -> LED_Out shows 0001, 0010, 0100, 1000, 0001 across successive slots, each bit high 3 cycles per slot; Slot_Done pulses every 10 cycles; Busy=1.
REQ-029 Reverse and ping-pong: Mode=01 -> active bit order 3,2,1,0,3; Mode=10 -> order 0,1,2,3,2,1,0,1.
REQ-030 All-blink: Mode=11 -> LED_Out=1111 for 3 of every 10 cycles; otherwise 0000.
REQ-031 Stop at Count=3 of the ch-2 slot -> bit 2 is still lit for counts 6..8, then one final Slot_Done; Busy=0 and LED_Out=0000 afterwards; the ch-3 slot never appears.
REQ-032 Start and Stop in the same cycle while IDLE -> the block stays IDLE with Busy=0; Start pulsed in RUN -> no restart and no Ch change; Mode toggled in RUN -> pattern unchanged.
REQ-033 RST pulsed at Count=7 with LED_Out=0100 -> all outputs go to 0 without waiting for a CLK edge; the block stays IDLE after release until the next Start.

Source files
------------

// File: rtl/led_scan_ctrl.sv
// Slot-timed 4-channel LED scanner: forward, reverse, ping-pong and all-blink patterns.
// Latency: every output is registered (LED_Out follows Count by one cycle); no backpressure, Stop drains the current slot.
module led_scan_ctrl #(
   parameter logic [24:0] T_SLOT   = 25'd20_000_000,
   parameter logic [24:0] ON_START = 25'd15_000_000,
   parameter logic [24:0] ON_END   = 25'd20_000_000
) (
   input  logic       CLK,
   input  logic       RST,
   input  logic       Start_Sig,
   input  logic       Stop_Sig,
   input  logic [1:0] Mode,
   output logic [3:0] LED_Out,
   output logic       Busy,
   output logic       Slot_Done
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_RUN   = 2'd1,
      S_DRAIN = 2'd2
   } state_t;

   localparam logic [24:0] LP_LAST = T_SLOT - 25'd1;

   state_t      r_state;
   logic [24:0] r_count;
   logic [1:0]  r_ch;
   logic        r_dir_up;
   logic [1:0]  r_mode;

   logic        w_wrap;
   logic        w_in_win;
   logic [3:0]  w_pattern;
   logic [3:0]  w_led_nxt;
   logic [1:0]  w_ch_nxt;
   logic        w_dir_nxt;
   logic [24:0] w_count_nxt;

   assign w_wrap      = (r_count == LP_LAST);
   assign w_in_win    = (r_count >= ON_START) && (r_count < ON_END);
   assign w_led_nxt   = w_in_win ? w_pattern : 4'b0000;
   assign w_count_nxt = w_wrap ? 25'd0 : r_count + 25'd1;

   always_comb begin
      w_pattern = 4'b0001 << r_ch;
      if (r_mode == 2'b11) begin
         w_pattern = 4'b1111;
      end
   end

   // Channel step applied only at a slot wrap; ping-pong turns around at both ends.
   always_comb begin
      w_ch_nxt  = r_ch;
      w_dir_nxt = r_dir_up;
      case (r_mode)
         2'b00: w_ch_nxt = r_ch + 2'd1;
         2'b01: w_ch_nxt = r_ch - 2'd1;
         2'b10: begin
            if (r_dir_up) begin
               if (r_ch == 2'd3) begin
                  w_dir_nxt = 1'b0;
                  w_ch_nxt  = 2'd2;
               end else begin
                  w_ch_nxt  = r_ch + 2'd1;
               end
            end else begin
               if (r_ch == 2'd0) begin
                  w_dir_nxt = 1'b1;
                  w_ch_nxt  = 2'd1;
               end else begin
                  w_ch_nxt  = r_ch - 2'd1;
               end
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         r_state   <= S_IDLE;
         r_count   <= 25'd0;
         r_ch      <= 2'd0;
         r_dir_up  <= 1'b1;
         r_mode    <= 2'b00;
         LED_Out   <= 4'b0000;
         Busy      <= 1'b0;
         Slot_Done <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               r_count   <= 25'd0;
               LED_Out   <= 4'b0000;
               Slot_Done <= 1'b0;
               if (Start_Sig && !Stop_Sig) begin
                  r_state  <= S_RUN;
                  r_mode   <= Mode;
                  r_dir_up <= 1'b1;
                  r_ch     <= (Mode == 2'b01) ? 2'd3 : 2'd0;
                  Busy     <= 1'b1;
               end else begin
                  Busy     <= 1'b0;
               end
            end
            S_RUN: begin
               LED_Out   <= w_led_nxt;
               Slot_Done <= w_wrap;
               r_count   <= w_count_nxt;
               Busy      <= 1'b1;
               if (w_wrap) begin
                  r_ch     <= w_ch_nxt;
                  r_dir_up <= w_dir_nxt;
               end
               if (Stop_Sig) begin
                  r_state <= S_DRAIN;
               end
            end
            S_DRAIN: begin
               // Finish the slot in progress; the channel stays put at the final wrap.
               LED_Out   <= w_led_nxt;
               Slot_Done <= w_wrap;
               r_count   <= w_count_nxt;
               if (w_wrap) begin
                  r_state <= S_IDLE;
                  Busy    <= 1'b0;
               end else begin
                  Busy    <= 1'b1;
               end
            end
            default: begin
               r_state   <= S_IDLE;
               r_count   <= 25'd0;
               LED_Out   <= 4'b0000;
               Busy      <= 1'b0;
               Slot_Done <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_led_scan_ctrl.sv
// Scoreboard bench for led_scan_ctrl with T_SLOT=10, ON_START=6, ON_END=9.
// Each slot record is {cycles in slot, OR of LED_Out, lit cycles, Busy at Slot_Done}.
module tb_led_scan_ctrl;

   logic       CLK = 1'b0;
   logic       RST = 1'b1;
   logic       Start_Sig = 1'b0;
   logic       Stop_Sig = 1'b0;
   logic [1:0] Mode = 2'b00;
   logic [3:0] LED_Out;
   logic       Busy;
   logic       Slot_Done;

   int checks = 0;
   int errors = 0;

   typedef logic [16:0] rec_t;
   rec_t exp_q[$];

   led_scan_ctrl #(
      .T_SLOT  (25'd10),
      .ON_START(25'd6),
      .ON_END  (25'd9)
   ) dut (
      .CLK      (CLK),
      .RST      (RST),
      .Start_Sig(Start_Sig),
      .Stop_Sig (Stop_Sig),
      .Mode     (Mode),
      .LED_Out  (LED_Out),
      .Busy     (Busy),
      .Slot_Done(Slot_Done)
   );

   always #5 CLK = ~CLK;

   // Monitor: accumulate each slot, compare on every Slot_Done pulse.
   logic [7:0] m_len = 8'd0;
   logic [3:0] m_or  = 4'd0;
   logic [3:0] m_lit = 4'd0;
   rec_t       m_exp;
   rec_t       m_got;

   always @(negedge CLK) begin
      if (!RST && LED_Out != 4'b0000 && exp_q.size() == 0) begin
         checks++;
         errors++;
         $display("FAIL spurious_led got=%b required=0000 (no slot expected)", LED_Out);
      end
      if (RST || (!Busy && !Slot_Done)) begin
         m_len = 8'd0;
         m_or  = 4'd0;
         m_lit = 4'd0;
      end else begin
         m_len = m_len + 8'd1;
         m_or  = m_or | LED_Out;
         if (LED_Out != 4'b0000) m_lit = m_lit + 4'd1;
         if (Slot_Done) begin
            checks++;
            m_got = {m_len, m_or, m_lit, Busy};
            if (exp_q.size() == 0) begin
               errors++;
               $display("FAIL spurious_slot_done got len=%0d led=%b lit=%0d busy=%b required=no slot",
                        m_len, m_or, m_lit, Busy);
            end else begin
               m_exp = exp_q.pop_front();
               if (m_got !== m_exp) begin
                  errors++;
                  $display("FAIL slot got len=%0d led=%b lit=%0d busy=%b required len=%0d led=%b lit=%0d busy=%b",
                           m_got[16:9], m_got[8:5], m_got[4:1], m_got[0],
                           m_exp[16:9], m_exp[8:5], m_exp[4:1], m_exp[0]);
               end
            end
            m_len = 8'd0;
            m_or  = 4'd0;
            m_lit = 4'd0;
         end
      end
   end

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h required=%0h", name, got, exp);
      end
   endtask

   task automatic wait_empty(input string name);
      for (int k = 0; k < 300; k++) begin
         if (exp_q.size() == 0) break;
         tick();
      end
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL %s_timeout got=%0d pending slots required=0", name, exp_q.size());
         exp_q.delete();
      end
   endtask

   // pat holds one expected LED nibble per slot (slot 0 in the LSBs); nibble n is the drained slot.
   task automatic run_scan(input logic [1:0] mode, input int n, input logic [63:0] pat,
                           input int stop_delay);
      logic [7:0] len;
      for (int i = 0; i < n; i++) begin
         len = (i == 0) ? 8'd11 : 8'd10;
         exp_q.push_back({len, pat[4*i +: 4], 4'd3, 1'b1});
      end
      Mode = mode;
      Start_Sig = 1'b1;
      tick();
      Start_Sig = 1'b0;
      Mode = ~mode;
      check("busy_after_start", {31'd0, Busy}, 32'd1);
      repeat (15) tick();
      Start_Sig = 1'b1;
      tick();
      Start_Sig = 1'b0;
      wait_empty("scan");
      repeat (stop_delay) tick();
      exp_q.push_back({8'd10, pat[4*n +: 4], 4'd3, 1'b0});
      Stop_Sig = 1'b1;
      tick();
      Stop_Sig = 1'b0;
      wait_empty("drain");
      repeat (3) tick();
      check("busy_after_drain", {31'd0, Busy}, 32'd0);
      check("led_after_drain", {28'd0, LED_Out}, 32'd0);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog got=timeout required=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      repeat (3) tick();
      check("rst_led", {28'd0, LED_Out}, 32'd0);
      check("rst_busy", {31'd0, Busy}, 32'd0);
      check("rst_slot_done", {31'd0, Slot_Done}, 32'd0);
      RST = 1'b0;
      repeat (2) tick();
      check("idle_busy", {31'd0, Busy}, 32'd0);

      run_scan(2'b00, 5, 64'h218421, 0);
      run_scan(2'b01, 5, 64'h481248, 0);
      run_scan(2'b10, 8, 64'h421248421, 0);
      run_scan(2'b11, 3, 64'hFFFF, 0);
      // Stop sampled at Count=3 of the ch-2 slot; ch-3 must never light.
      run_scan(2'b00, 2, 64'h421, 2);
      repeat (30) tick();
      check("no_ch3_busy", {31'd0, Busy}, 32'd0);

      Start_Sig = 1'b1;
      Stop_Sig  = 1'b1;
      tick();
      Start_Sig = 1'b0;
      Stop_Sig  = 1'b0;
      check("start_stop_busy", {31'd0, Busy}, 32'd0);
      repeat (12) tick();
      check("start_stop_busy_later", {31'd0, Busy}, 32'd0);
      check("start_stop_led", {28'd0, LED_Out}, 32'd0);

      exp_q.push_back({8'd11, 4'b0001, 4'd3, 1'b1});
      exp_q.push_back({8'd10, 4'b0010, 4'd3, 1'b1});
      Mode = 2'b00;
      Start_Sig = 1'b1;
      tick();
      Start_Sig = 1'b0;
      wait_empty("rst_scan");
      exp_q.push_back({8'd10, 4'b0100, 4'd3, 1'b1});
      repeat (6) tick();
      check("pre_rst_led", {28'd0, LED_Out}, 32'h4);
      check("pre_rst_busy", {31'd0, Busy}, 32'd1);
      #2;
      RST = 1'b1;
      #1;
      check("async_rst_led", {28'd0, LED_Out}, 32'd0);
      check("async_rst_busy", {31'd0, Busy}, 32'd0);
      check("async_rst_slot_done", {31'd0, Slot_Done}, 32'd0);
      exp_q.delete();
      repeat (2) tick();
      RST = 1'b0;
      repeat (25) tick();
      check("post_rst_busy", {31'd0, Busy}, 32'd0);
      check("post_rst_led", {28'd0, LED_Out}, 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
